// File: rtl/timer_pkg.sv
// Shared definitions for the command-driven timer controller:
// op codes, FSM state encoding, CONTROL bit indices and reset constants.
package timer_pkg;

   typedef enum logic [1:0] {
      OP_PERIOD   = 2'd0,
      OP_COMPARE  = 2'd1,
      OP_PRESCALE = 2'd2,
      OP_CONTROL  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int CTL_START    = 0;
   localparam int CTL_PERIODIC = 1;

   localparam logic [7:0] RST_PERIOD   = 8'hFF;
   localparam logic [7:0] RST_COMPARE  = 8'hFF;
   localparam logic [7:0] RST_PRESCALE = 8'h00;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: divides clk into ticks, one tick every (prescale+1) enabled cycles.
// Ports: clk, rst (sync, active-high), clear, enable, prescale -> tick.
module timer_prescaler #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt;

   assign tick = enable && (cnt == prescale);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// Command-driven timer: byte commands program period/compare/prescale and
// start/stop an up-counter in one-shot or periodic mode.
// Ports: clk, rst (sync, active-high), cmd_valid/cmd_ready/cmd_op/cmd_data,
// count, running, done, match_pulse, wrap_pulse, pwm_out (TIMER_PWM_EN only).
module timer_ctrl #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [7:0]       cmd_data,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             done,
`ifdef TIMER_PWM_EN
   output logic             pwm_out,
`endif
   output logic             match_pulse,
   output logic             wrap_pulse
);

   import timer_pkg::*;

   state_t                state, state_d;
   logic [WIDTH-1:0]      period, compare, compare_d;
   logic [PRESCALE_W-1:0] prescale;
   logic                  periodic, periodic_d;
   logic [WIDTH-1:0]      count_d, count_inc;
   logic                  match_d, wrap_d;
   logic                  cmd_acc, ctl_acc, tick;

   // Period and prescale are frozen while running so a wrap can't be missed.
   assign cmd_ready = !((state == ST_RUN) &&
                        ((cmd_op == OP_PERIOD) || (cmd_op == OP_PRESCALE)));
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign ctl_acc   = cmd_acc && (cmd_op == OP_CONTROL);
   assign count_inc = count + WIDTH'(1);

   timer_prescaler #(
      .PRESCALE_W(PRESCALE_W)
   ) u_presc (
      .clk      (clk),
      .rst      (rst),
      .clear    (ctl_acc),
      .enable   (state == ST_RUN),
      .prescale (prescale),
      .tick     (tick)
   );

   always_comb begin
      state_d    = state;
      count_d    = count;
      periodic_d = periodic;
      compare_d  = compare;
      match_d    = 1'b0;
      wrap_d     = 1'b0;
      if (cmd_acc && (cmd_op == OP_COMPARE)) begin
         compare_d = WIDTH'(cmd_data);
      end
      // A CONTROL command discards any tick in the same cycle.
      if (ctl_acc) begin
         if (cmd_data[CTL_START]) begin
            state_d    = ST_RUN;
            count_d    = '0;
            periodic_d = cmd_data[CTL_PERIODIC];
            match_d    = (compare == '0);
         end else begin
            state_d = ST_IDLE;
         end
      end else if (tick) begin
         if (count == period) begin
            wrap_d = 1'b1;
            if (periodic) begin
               count_d = '0;
               match_d = (compare == '0);
            end else begin
               state_d = ST_DONE;
            end
         end else begin
            count_d = count_inc;
            match_d = (count_inc == compare);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         count       <= '0;
         period      <= WIDTH'(RST_PERIOD);
         compare     <= WIDTH'(RST_COMPARE);
         prescale    <= PRESCALE_W'(RST_PRESCALE);
         periodic    <= 1'b0;
         running     <= 1'b0;
         done        <= 1'b0;
         match_pulse <= 1'b0;
         wrap_pulse  <= 1'b0;
      end else begin
         state       <= state_d;
         count       <= count_d;
         compare     <= compare_d;
         periodic    <= periodic_d;
         running     <= (state_d == ST_RUN);
         done        <= (state_d == ST_DONE);
         match_pulse <= match_d;
         wrap_pulse  <= wrap_d;
         if (cmd_acc && (cmd_op == OP_PERIOD)) begin
            period <= WIDTH'(cmd_data);
         end
         if (cmd_acc && (cmd_op == OP_PRESCALE)) begin
            prescale <= PRESCALE_W'(cmd_data);
         end
      end
   end

`ifdef TIMER_PWM_EN
   logic pwm_d;

   assign pwm_d = (state_d == ST_RUN) && (count_d < compare_d);

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= pwm_d;
      end
   end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl.
// Covers reset, periodic/one-shot runs, handshake stalls, compare, stop/restart.
module tb_timer_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic [7:0] count;
   logic       running;
   logic       done;
   logic       match_pulse;
   logic       wrap_pulse;
`ifdef TIMER_PWM_EN
   logic       pwm_out;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   timer_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_data    (cmd_data),
      .count       (count),
      .running     (running),
      .done        (done),
`ifdef TIMER_PWM_EN
      .pwm_out     (pwm_out),
`endif
      .match_pulse (match_pulse),
      .wrap_pulse  (wrap_pulse)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      cyc();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int e;
      int highs;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_data  = 8'd0;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();

      // reset state
      chk("rst_count", 32'(count), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_match", 32'(match_pulse), 0);
      chk("rst_wrap", 32'(wrap_pulse), 0);
      for (int op = 0; op < 4; op++) begin
         cmd_op = 2'(op);
         #1;
         chk("rst_ready", 32'(cmd_ready), 1);
      end

      // default period 0xFF, compare 0xFF, periodic run
      send(2'd3, 8'h03);
      chk("def_start_count", 32'(count), 0);
      chk("def_running", 32'(running), 1);
      repeat (254) cyc();
      chk("def_count254", 32'(count), 254);
      chk("def_nomatch", 32'(match_pulse), 0);
      cyc();
      chk("def_count255", 32'(count), 255);
      chk("def_match255", 32'(match_pulse), 1);
      cyc();
      chk("def_wrap_count", 32'(count), 0);
      chk("def_wrap", 32'(wrap_pulse), 1);
      send(2'd3, 8'h00);
      chk("def_stop_count", 32'(count), 0);
      chk("def_stop_run", 32'(running), 0);

      // period 4, prescale 0, periodic
      send(2'd0, 8'd4);
      send(2'd2, 8'd0);
      send(2'd3, 8'h03);
      for (int i = 0; i <= 10; i++) begin
         if (i > 0) cyc();
         chk("p4_count", 32'(count), 32'(i % 5));
         chk("p4_wrap", 32'(wrap_pulse), 32'((i > 0) && (i % 5 == 0)));
         chk("p4_running", 32'(running), 1);
      end

      // stalls while running, compare rewrite
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_data  = 8'd9;
      #1;
      chk("run_ready_period", 32'(cmd_ready), 0);
      cmd_op = 2'd2;
      #1;
      chk("run_ready_presc", 32'(cmd_ready), 0);
      cmd_op = 2'd0;
      cyc();
      chk("stall_count", 32'(count), 1);
      cmd_op   = 2'd1;
      cmd_data = 8'd2;
      #1;
      chk("run_ready_cmp", 32'(cmd_ready), 1);
      cyc();
      cmd_valid = 1'b0;
      chk("cmp_wr_count", 32'(count), 2);
      chk("cmp_wr_nomatch", 32'(match_pulse), 0);
      for (int j = 1; j <= 10; j++) begin
         cyc();
         e = (2 + j) % 5;
         chk("cmp_count", 32'(count), 32'(e));
         chk("cmp_match", 32'(match_pulse), 32'(e == 2));
         chk("cmp_wrap", 32'(wrap_pulse), 32'(e == 0));
      end

      // stop / restart with compare 0, then reset mid-run
      send(2'd3, 8'h00);
      send(2'd0, 8'd9);
      send(2'd1, 8'd0);
      send(2'd3, 8'h03);
      chk("c0_start_count", 32'(count), 0);
      chk("c0_start_match", 32'(match_pulse), 1);
      repeat (5) cyc();
      chk("c0_count5", 32'(count), 5);
      chk("c0_match5", 32'(match_pulse), 0);
      send(2'd3, 8'h00);
      chk("pause_count", 32'(count), 5);
      chk("pause_running", 32'(running), 0);
      repeat (3) cyc();
      chk("pause_hold", 32'(count), 5);
      send(2'd3, 8'h03);
      chk("restart_count", 32'(count), 0);
      chk("restart_match", 32'(match_pulse), 1);
      cyc();
      chk("restart_count1", 32'(count), 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mrst_count", 32'(count), 0);
      chk("mrst_running", 32'(running), 0);
      chk("mrst_match", 32'(match_pulse), 0);
      chk("mrst_wrap", 32'(wrap_pulse), 0);
      chk("mrst_done", 32'(done), 0);

      // one-shot, period 3, prescale 2
      send(2'd0, 8'd3);
      send(2'd2, 8'd2);
      send(2'd3, 8'h01);
      chk("os_start", 32'(count), 0);
      for (int k = 1; k <= 13; k++) begin
         cyc();
         chk("os_count", 32'(count), (k >= 12) ? 32'd3 : 32'(k / 3));
         chk("os_wrap", 32'(wrap_pulse), 32'(k == 12));
         chk("os_done", 32'(done), 32'(k >= 12));
      end
      chk("os_running", 32'(running), 0);
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_data  = 8'd7;
      #1;
      chk("done_ready_period", 32'(cmd_ready), 1);
      cyc();
      cmd_valid = 1'b0;
      send(2'd2, 8'd0);
      send(2'd3, 8'h01);
      repeat (7) cyc();
      chk("os7_count", 32'(count), 7);
      chk("os7_running", 32'(running), 1);
      cyc();
      chk("os7_wrap", 32'(wrap_pulse), 1);
      chk("os7_done", 32'(done), 1);
      chk("os7_hold", 32'(count), 7);

`ifdef TIMER_PWM_EN
      send(2'd0, 8'd9);
      send(2'd1, 8'd3);
      send(2'd3, 8'h03);
      highs = 0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) cyc();
         highs += int'(pwm_out);
      end
      chk("pwm_highs", 32'(highs), 3);
      send(2'd3, 8'h00);
      chk("pwm_idle", 32'(pwm_out), 0);
`else
      highs = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
